// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and byte-wide CRC-32 step for the Ethernet RX FCS checker.
package eth_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned DELAY_DEPTH = 5;
  localparam int unsigned DLY_CNT_W   = $clog2(DELAY_DEPTH + 1);

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_END,
    ST_DROP
  } rx_state_e;

  // MSB-first register with rxd[0] shifted in first; a clean frame leaves CRC_RESIDUE
  function automatic logic [31:0] crc32_d8_next(input logic [7:0] data, input logic [31:0] crc);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// Payload stream plus per-frame status leaving the RX FCS checker.
interface eth_rx_fcs_check_if;
  import eth_pkg::*;

  logic [BYTE_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              frame_done;
  logic              frame_good;
  logic              frame_crc_err;
  logic              frame_runt;
  logic              frame_giant;
  logic              frame_rxer;
  logic [LEN_W-1:0]  frame_len;

  modport master (
    output m_data, m_valid, m_last,
    output frame_done, frame_good, frame_crc_err, frame_runt, frame_giant, frame_rxer, frame_len
  );

  modport slave (
    input m_data, m_valid, m_last,
    input frame_done, frame_good, frame_crc_err, frame_runt, frame_giant, frame_rxer, frame_len
  );

endinterface

// File: rtl/eth_rx_fcs_delay.sv
// 5-deep byte delay line that hides the trailing FCS: a byte leaves only once four newer bytes exist.
module eth_rx_fcs_delay
  import eth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 flush,
  input  logic [BYTE_W-1:0]    din,
  output logic [DLY_CNT_W-1:0] count,
  output logic [BYTE_W-1:0]    m_data,
  output logic                 m_valid,
  output logic                 m_last
);

  logic [BYTE_W-1:0] sr [DELAY_DEPTH];
  logic              full_c;

  assign full_c = (count == DLY_CNT_W'(DELAY_DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DELAY_DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // On flush the oldest entry is the last payload byte; the other four are the FCS and are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      if (push) begin
        if (full_c) begin
          m_valid <= 1'b1;
          m_data  <= sr[DELAY_DEPTH-1];
        end else begin
          count <= count + DLY_CNT_W'(1);
        end
      end else if (flush) begin
        if (full_c) begin
          m_valid <= 1'b1;
          m_last  <= 1'b1;
          m_data  <= sr[DELAY_DEPTH-1];
        end
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII RX front end: strips preamble/SFD, streams payload without FCS, reports one status per frame.
// Optional ETH_RX_FCS_STATS_EN adds good/bad frame counters.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned MAX_BYTES = 1522
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] gmii_rxd,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  eth_rx_fcs_check_if.master rx
`ifdef ETH_RX_FCS_STATS_EN
  ,
  output logic [31:0]       stat_good_cnt,
  output logic [31:0]       stat_bad_cnt
`endif
);

  rx_state_e            state;
  logic [31:0]          crc;
  logic [LEN_W-1:0]     len;
  logic                 rxer;
  logic [DLY_CNT_W-1:0] dly_count;

  logic dly_push_c, dly_flush_c;
  logic crc_bad_c, runt_c, giant_c;

  assign dly_push_c  = (state == ST_DATA) && gmii_rx_dv;
  assign dly_flush_c = (state == ST_DATA) && !gmii_rx_dv;

  // A frame that never filled the delay line (4 bytes or fewer) has no payload and is always a runt
  always_comb begin
    crc_bad_c = (crc != CRC_RESIDUE);
    runt_c    = (32'(len) < MIN_BYTES) || (dly_count != DLY_CNT_W'(DELAY_DEPTH));
    giant_c   = (32'(len) > MAX_BYTES);
  end

  eth_rx_fcs_delay u_delay (
    .clk     (clk),
    .rst     (rst),
    .push    (dly_push_c),
    .flush   (dly_flush_c),
    .din     (gmii_rxd),
    .count   (dly_count),
    .m_data  (rx.m_data),
    .m_valid (rx.m_valid),
    .m_last  (rx.m_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      crc              <= CRC_INIT;
      len              <= '0;
      rxer             <= 1'b0;
      rx.frame_done    <= 1'b0;
      rx.frame_good    <= 1'b0;
      rx.frame_crc_err <= 1'b0;
      rx.frame_runt    <= 1'b0;
      rx.frame_giant   <= 1'b0;
      rx.frame_rxer    <= 1'b0;
      rx.frame_len     <= '0;
    end else begin
      rx.frame_done    <= 1'b0;
      rx.frame_good    <= 1'b0;
      rx.frame_crc_err <= 1'b0;
      rx.frame_runt    <= 1'b0;
      rx.frame_giant   <= 1'b0;
      rx.frame_rxer    <= 1'b0;
      rx.frame_len     <= '0;
      unique case (state)
        // END doubles as the inter-frame gap, so it may start the next preamble directly
        ST_IDLE, ST_END: begin
          if (gmii_rx_dv && gmii_rxd == ETH_PREAMBLE) state <= ST_PRE;
          else                                        state <= ST_IDLE;
        end
        ST_PRE: begin
          if (!gmii_rx_dv) begin
            state <= ST_IDLE;
          end else if (gmii_rxd == ETH_SFD) begin
            state <= ST_DATA;
            crc   <= CRC_INIT;
            len   <= '0;
            rxer  <= 1'b0;
          end else if (gmii_rxd != ETH_PREAMBLE) begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (gmii_rx_dv) begin
            crc  <= crc32_d8_next(gmii_rxd, crc);
            len  <= (len == '1) ? len : len + LEN_W'(1);
            rxer <= rxer | gmii_rx_er;
          end else begin
            state            <= ST_END;
            rx.frame_done    <= 1'b1;
            rx.frame_crc_err <= crc_bad_c;
            rx.frame_runt    <= runt_c;
            rx.frame_giant   <= giant_c;
            rx.frame_rxer    <= rxer;
            rx.frame_good    <= !(crc_bad_c || runt_c || giant_c || rxer);
            rx.frame_len     <= len;
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ETH_RX_FCS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_cnt <= '0;
      stat_bad_cnt  <= '0;
    end else if (rx.frame_done) begin
      if (rx.frame_good) stat_good_cnt <= stat_good_cnt + 32'd1;
      else               stat_bad_cnt  <= stat_bad_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: two instances (relaxed and default length limits) checked
// every cycle against a frame-level reference model.
module tb_eth_rx_fcs_check;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed { logic [7:0] d; logic last; } beat_t;
  typedef struct packed {
    logic good, crc_err, runt, giant, rxer;
    logic [15:0] len;
  } status_t;

  localparam int MIN_B [2] = '{0, 64};
  localparam int MAX_B [2] = '{40, 1522};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxd;
  logic       dv, er;

  always #4 clk = ~clk;

  eth_rx_fcs_check_if if0 ();
  eth_rx_fcs_check_if if1 ();

`ifdef ETH_RX_FCS_STATS_EN
  logic [31:0] sg0, sb0, sg1, sb1;
`endif

  eth_rx_fcs_check #(.MIN_BYTES(0), .MAX_BYTES(40)) u0 (
    .clk(clk), .rst(rst), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er), .rx(if0)
`ifdef ETH_RX_FCS_STATS_EN
    , .stat_good_cnt(sg0), .stat_bad_cnt(sb0)
`endif
  );

  eth_rx_fcs_check u1 (
    .clk(clk), .rst(rst), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er), .rx(if1)
`ifdef ETH_RX_FCS_STATS_EN
    , .stat_good_cnt(sg1), .stat_bad_cnt(sb1)
`endif
  );

  beat_t   eb [2][$];
  status_t es [2][$];
  int      n_total = 0;
  int      n_bad   = 0;
  int      done_cnt [2] = '{0, 0};
  int      beat_cnt [2] = '{0, 0};
  status_t last_st  [2];
  beat_t   cap0 [$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard reflected CRC-32 over a byte list; a frame with correct FCS leaves 32'hDEBB20E3
  function automatic logic [31:0] crc_refl(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[j]) begin
      c = c ^ {24'h0, b[j]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    byte_q_t     f;
    logic [31:0] c;
    f = p;
    c = ~crc_refl(p);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  function automatic byte_q_t ramp(input int n, input int seed);
    byte_q_t f;
    for (int i = 0; i < n; i++) f.push_back(8'(seed + 7 * i));
    return f;
  endfunction

  // Expected beats and status for both instances; a reset at body index r yields only bytes 0..r-6
  task automatic model_frame(input byte_q_t f, input int er_at, input int rst_at);
    int      len;
    logic    crc_err;
    status_t s;
    len     = f.size();
    crc_err = (crc_refl(f) != 32'hDEBB20E3);
    for (int i = 0; i < 2; i++) begin
      if (rst_at >= 0) begin
        for (int k = 0; k <= rst_at - 6; k++) eb[i].push_back('{d: f[k], last: 1'b0});
      end else begin
        for (int k = 0; k <= len - 5; k++) eb[i].push_back('{d: f[k], last: (k == len - 5)});
        s.crc_err = crc_err;
        s.runt    = (len < MIN_B[i]) || (len <= 4);
        s.giant   = (len > MAX_B[i]);
        s.rxer    = (er_at >= 0) && (er_at < len);
        s.good    = !(s.crc_err || s.runt || s.giant || s.rxer);
        s.len     = 16'(len);
        es[i].push_back(s);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input byte_q_t f, input int er_at, input int rst_at);
    for (int i = 0; i < 8; i++) begin
      dv = 1'b1; er = 1'b0; rxd = (i == 7) ? 8'hD5 : 8'h55;
      tick();
    end
    for (int i = 0; i < f.size(); i++) begin
      if (i == rst_at) begin
        dv = 1'b0; rxd = 8'h00; er = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      dv = 1'b1; rxd = f[i]; er = (i == er_at);
      tick();
    end
    dv = 1'b0; rxd = 8'h00; er = 1'b0;
    tick();
  endtask

  task automatic send(input byte_q_t f, input int er_at, input int rst_at);
    model_frame(f, er_at, rst_at);
    drive_frame(f, er_at, rst_at);
  endtask

  task automatic drive_raw(input byte_q_t b);
    foreach (b[i]) begin
      dv = 1'b1; rxd = b[i]; er = 1'b0;
      tick();
    end
    dv = 1'b0; rxd = 8'h00;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_inst(input int i, input logic [7:0] d, input logic v, input logic l,
                            input logic dn, input status_t st);
    beat_t   b;
    status_t s;
    if (v) begin
      beat_cnt[i]++;
      if (i == 0) cap0.push_back('{d: d, last: l});
      if (eb[i].size() == 0) begin
        cmp($sformatf("unexpected_beat%0d", i), 32'(v), 32'(1'b0));
      end else begin
        b = eb[i].pop_front();
        cmp($sformatf("beat%0d", i), {23'h0, d, l}, {23'h0, b.d, b.last});
      end
    end else if (l) begin
      cmp($sformatf("last_without_valid%0d", i), 32'(l), 32'(1'b0));
    end
    if (dn) begin
      done_cnt[i]++;
      last_st[i] = st;
      if (es[i].size() == 0) begin
        cmp($sformatf("unexpected_done%0d", i), 32'(dn), 32'(1'b0));
      end else begin
        s = es[i].pop_front();
        cmp($sformatf("status%0d", i), 32'(st), 32'(s));
      end
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, if0.m_data, if0.m_valid, if0.m_last, if0.frame_done,
               '{good: if0.frame_good, crc_err: if0.frame_crc_err, runt: if0.frame_runt,
                 giant: if0.frame_giant, rxer: if0.frame_rxer, len: if0.frame_len});
    check_inst(1, if1.m_data, if1.m_valid, if1.m_last, if1.frame_done,
               '{good: if1.frame_good, crc_err: if1.frame_crc_err, runt: if1.frame_runt,
                 giant: if1.frame_giant, rxer: if1.frame_rxer, len: if1.frame_len});
  end

  task automatic check_zero(input string name);
    @(negedge clk);
    cmp({name, "_u0"}, {if0.m_data, if0.m_valid, if0.m_last, if0.frame_done, if0.frame_good,
        if0.frame_crc_err, if0.frame_runt, if0.frame_giant, if0.frame_rxer, if0.frame_len}, 32'h0);
    cmp({name, "_u1"}, {if1.m_data, if1.m_valid, if1.m_last, if1.frame_done, if1.frame_good,
        if1.frame_crc_err, if1.frame_runt, if1.frame_giant, if1.frame_rxer, if1.frame_len}, 32'h0);
    #1;
  endtask

  initial begin
    byte_q_t p9, f1, f2, f64, f63, f40, f41, f3, f5;
    int      d0, d1, bc1;
`ifdef ETH_RX_FCS_STATS_EN
    int      base0, base1;
`endif
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    cmp("model_check_value", ~crc_refl(p9), 32'hCBF43926);
    f2 = with_fcs(p9);
    cmp("model_fcs_bytes", {f2[12], f2[11], f2[10], f2[9]}, 32'hCBF43926);

    // Known-answer frame with the "123456789" payload
    cap0.delete();
    send(f1, -1, -1);
    idle(3);
    cmp("t1_nbeats", 32'(cap0.size()), 32'd9);
    for (int i = 0; i < cap0.size() && i < 9; i++) begin
      cmp($sformatf("t1_byte%0d", i), {23'h0, cap0[i].d, cap0[i].last}, {23'h0, 8'(8'h31 + i), (i == 8)});
    end
    cmp("t1_good", 32'(last_st[0].good), 32'd1);
    cmp("t1_len", 32'(last_st[0].len), 32'd13);

    // Corrupted last FCS byte
    f2 = f1;
    f2[12] = 8'hCA;
    cap0.delete();
    send(f2, -1, -1);
    idle(3);
    cmp("t2_nbeats", 32'(cap0.size()), 32'd9);
    cmp("t2_crc_err_good", {30'h0, last_st[0].crc_err, last_st[0].good}, 32'b10);

    // Minimum-size frame and one byte short
    f64 = with_fcs(ramp(60, 8'h10));
    f63 = with_fcs(ramp(59, 8'h40));
    bc1 = beat_cnt[1];
    send(f64, -1, -1);
    idle(3);
    cmp("t3_beats64", 32'(beat_cnt[1] - bc1), 32'd60);
    cmp("t3_good64", {last_st[1].good, last_st[1].runt, last_st[1].len}, {1'b1, 1'b0, 16'd64});
    cmp("t3_giant_u0", 32'(last_st[0].giant), 32'd1);
    send(f63, -1, -1);
    idle(3);
    cmp("t3_runt63", {last_st[1].good, last_st[1].runt, last_st[1].len}, {1'b0, 1'b1, 16'd63});

    // Back-to-back frames separated by a single dv-low cycle
    f40 = with_fcs(ramp(36, 8'h80));
    d0 = done_cnt[0];
    send(f1, -1, -1);
    send(f40, -1, -1);
    idle(3);
    cmp("t4_two_done", 32'(done_cnt[0] - d0), 32'd2);
    cmp("t4_second", {last_st[0].good, last_st[0].len}, {1'b1, 16'd40});

    // rx_er inside DATA, then an aborted preamble
    send(f64, 10, -1);
    idle(3);
    cmp("t5_rxer", {30'h0, last_st[1].rxer, last_st[1].good}, 32'b10);
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    drive_raw('{8'h55, 8'h55, 8'hAA, 8'hD5, 8'h12, 8'h34});
    idle(3);
    cmp("t5_drop_no_done", 32'((done_cnt[0] - d0) + (done_cnt[1] - d1)), 32'd0);

    // Length boundaries: 3 bytes, 5 bytes, one over the relaxed maximum
    f3 = '{8'h01, 8'h02, 8'h03};
    f5 = with_fcs('{8'hAB});
    f41 = with_fcs(ramp(37, 8'h05));
    send(f3, -1, -1);
    send(f5, -1, -1);
    send(f41, -1, -1);
    idle(3);
    cmp("t5_giant41", {last_st[0].giant, last_st[0].good}, 32'b10);

    // Reset in the middle of a frame, then recovery
    d0 = done_cnt[0];
    send(f40, -1, 20);
    check_zero("t6_after_rst");
`ifdef ETH_RX_FCS_STATS_EN
    base0 = done_cnt[0];
    base1 = done_cnt[1];
`endif
    idle(2);
    cmp("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);
    send(f1, -1, -1);
    idle(3);
    cmp("t6_recover", {last_st[0].good, last_st[0].len}, {1'b1, 16'd13});

    idle(5);
    cmp("beats_drained", 32'(eb[0].size() + eb[1].size()), 32'd0);
    cmp("status_drained", 32'(es[0].size() + es[1].size()), 32'd0);
`ifdef ETH_RX_FCS_STATS_EN
    cmp("stats_u0", sg0 + sb0, 32'(done_cnt[0] - base0));
    cmp("stats_u1", sg1 + sb1, 32'(done_cnt[1] - base1));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
